c15xx_head_ctrl: RTL and testbench

Parametrised drive-mechanics controller for the C1541/C1571 drive cores: decodes stepper phases into a clamped half-track position, tracks a selectable head side, and flags track-buffer modification. On head move, side change or activity stop it raises a save request carrying a snapshot of the departing track/side. It also generates write-protect and track-0 sense. It sits between `c1541_logic`/VIA outputs and the track buffer/SD sector engine, replacing the inline stepper/save logic of the single-sided drive top.

---
 rtl/c15xx_pkg.sv | 26 ++
 rtl/c15xx_change_timer.sv | 60 ++++++
 rtl/c15xx_head_ctrl.sv | 141 ++++++++++++++
 tb/tb_c15xx_head_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/c15xx_pkg.sv
// Shared types and helpers for the C1541/C1571 drive-mechanics blocks:
// stepper-phase direction decode and default geometry constants.
package c15xx_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

  localparam int DEF_MAX_HALFTRACK   = 80;
  localparam int DEF_RESET_HALFTRACK = 36;
  localparam int DEF_CHANGE_CYCLES   = 15000000;

  // Phase pairs one position apart in the 0-2-1-3 rotation are steps; others are noise.
  function automatic step_e step_dir(input logic [1:0] prev, input logic [1:0] cur);
    step_e d;
    case ({prev, cur})
      4'b00_10, 4'b10_01, 4'b01_11, 4'b11_00: d = STEP_UP;
      4'b00_11, 4'b10_00, 4'b01_10, 4'b11_01: d = STEP_DOWN;
      default:                                d = STEP_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/c15xx_change_timer.sv
// Disk-change edge detector with readonly latch and a saturating window
// counter; ch_active is high while the write-protect toggle window runs.
module c15xx_change_timer
  import c15xx_pkg::*;
#(
  parameter int CHANGE_CYCLES = DEF_CHANGE_CYCLES,
  localparam int CW = (CHANGE_CYCLES < 1) ? 1 : $clog2(CHANGE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic disk_change,
  input  logic disk_readonly,
  output logic change_edge,
  output logic readonly,
  output logic ch_active
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(CHANGE_CYCLES);

  logic          dc_r;
  logic          ro_r;
  logic          ch_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          ro_nxt_s;

  assign change_edge = disk_change & ~dc_r;
  assign readonly    = ro_r;
  assign ch_active   = ch_r;

  // Next-state for the window counter and the readonly latch.
  always_comb begin
    cnt_nxt_s = cnt_r;
    ro_nxt_s  = ro_r;
    if (change_edge) begin
      cnt_nxt_s = LOAD_VAL;
      ro_nxt_s  = disk_readonly;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_nxt_s = cnt_r - CW'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Edge-detect register, counter, latch and registered window flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      dc_r  <= 1'b0;
      ro_r  <= 1'b0;
      cnt_r <= {CW{1'b0}};
      ch_r  <= 1'b0;
    end else begin
      dc_r  <= disk_change;
      ro_r  <= ro_nxt_s;
      cnt_r <= cnt_nxt_s;
      ch_r  <= (cnt_nxt_s != {CW{1'b0}});
    end
  end

endmodule

// File: rtl/c15xx_head_ctrl.sv
// Drive head controller: stepper decode to clamped half-track, head side,
// dirty tracking and a single-entry save request with overrun flag.
module c15xx_head_ctrl
  import c15xx_pkg::*;
#(
  parameter int MAX_HALFTRACK   = DEF_MAX_HALFTRACK,
  parameter int RESET_HALFTRACK = DEF_RESET_HALFTRACK,
  parameter int CHANGE_CYCLES   = DEF_CHANGE_CYCLES,
  parameter int SIDES           = 1,
  localparam int HTW            = $clog2(MAX_HALFTRACK + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mtr,
  input  logic [1:0]     stp,
  input  logic           act,
  input  logic           side_i,
  input  logic           buff_we,
  input  logic           disk_change,
  input  logic           disk_readonly,
  input  logic           save_ack,
  output logic [HTW-2:0] track,
  output logic           side,
  output logic           tr00_sense_n,
  output logic           wps_n,
  output logic           save_req,
  output logic [HTW-2:0] save_track,
  output logic           save_side,
  output logic           overrun
);

  localparam logic [HTW-1:0] MAX_HT = HTW'(MAX_HALFTRACK);
  localparam logic [HTW-1:0] RST_HT = HTW'(RESET_HALFTRACK);
  localparam logic [HTW-1:0] ONE_HT = HTW'(1);

  logic [HTW-1:0] halftrack_r;
  logic [HTW-1:0] halftrack_nxt_s;
  logic [1:0]     stp_r;
  logic           act_r;
  logic           side_r;
  logic           dirty_r;
  logic           save_req_r;
  logic [HTW-2:0] save_track_r;
  logic           save_side_r;
  logic           overrun_r;
  logic           tr00_n_r;

  step_e          dir_s;
  logic           step_ev_s;
  logic           side_ev_s;
  logic           act_ev_s;
  logic           save_ev_s;
  logic           issue_s;
  logic           change_edge_s;
  logic           readonly_s;
  logic           ch_active_s;

  c15xx_change_timer #(
    .CHANGE_CYCLES(CHANGE_CYCLES)
  ) u_change_timer (
    .clk          (clk),
    .reset        (reset),
    .disk_change  (disk_change),
    .disk_readonly(disk_readonly),
    .change_edge  (change_edge_s),
    .readonly     (readonly_s),
    .ch_active    (ch_active_s)
  );

  assign track        = halftrack_r[HTW-1:1];
  assign side         = side_r;
  assign tr00_sense_n = tr00_n_r;
  assign wps_n        = ~readonly_s ^ ch_active_s;
  assign save_req     = save_req_r;
  assign save_track   = save_track_r;
  assign save_side    = save_side_r;
  assign overrun      = overrun_r;

  // Event decode and clamped half-track next state.
  always_comb begin
    dir_s     = step_dir(stp_r, stp);
    step_ev_s = mtr && (dir_s != STEP_NONE);
    side_ev_s = (SIDES == 2) ? (side_i != side_r) : 1'b0;
    act_ev_s  = act_r & ~act;
    save_ev_s = step_ev_s | side_ev_s | act_ev_s;
    // A write landing in the event cycle still belongs to the departing track.
    issue_s   = save_ev_s && (dirty_r || buff_we) && !change_edge_s;
    halftrack_nxt_s = halftrack_r;
    if (step_ev_s && (dir_s == STEP_UP) && (halftrack_r < MAX_HT)) begin
      halftrack_nxt_s = halftrack_r + ONE_HT;
    end else if (step_ev_s && (dir_s == STEP_DOWN) && (halftrack_r > ONE_HT)) begin
      halftrack_nxt_s = halftrack_r - ONE_HT;
    end else begin
      halftrack_nxt_s = halftrack_r;
    end
  end

  // Head position, side, dirty flag and save handshake state.
  always_ff @(posedge clk) begin
    if (reset) begin
      halftrack_r  <= RST_HT;
      tr00_n_r     <= (RST_HT[HTW-1:1] != {(HTW-1){1'b0}});
      stp_r        <= 2'd0;
      act_r        <= 1'b0;
      side_r       <= 1'b0;
      dirty_r      <= 1'b0;
      save_req_r   <= 1'b0;
      save_track_r <= {(HTW-1){1'b0}};
      save_side_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      stp_r       <= stp;
      act_r       <= act;
      halftrack_r <= halftrack_nxt_s;
      tr00_n_r    <= (halftrack_nxt_s[HTW-1:1] != {(HTW-1){1'b0}});
      side_r      <= (SIDES == 2) ? side_i : 1'b0;

      if (change_edge_s || save_ev_s) begin
        dirty_r <= 1'b0;
      end else if (buff_we) begin
        dirty_r <= 1'b1;
      end

      // A new disk discards any pending save of the old image.
      if (change_edge_s) begin
        save_req_r <= 1'b0;
      end else if (issue_s && !save_req_r) begin
        save_req_r   <= 1'b1;
        save_track_r <= halftrack_r[HTW-1:1];
        save_side_r  <= side_r;
      end else if (save_req_r && save_ack) begin
        save_req_r <= 1'b0;
      end

      if (issue_s && save_req_r) begin
        overrun_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c15xx_head_ctrl.sv
// Directed bench for c15xx_head_ctrl: a single-sided and a double-sided
// instance share stimulus; outputs are checked against hand-derived values.
module tb_c15xx_head_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       mtr;
  logic [1:0] stp;
  logic       act;
  logic       side_i;
  logic       buff_we;
  logic       disk_change;
  logic       disk_readonly;
  logic       save_ack;

  logic [5:0] a_track, a_save_track, b_track, b_save_track;
  logic       a_side, a_tr00_n, a_wps_n, a_save_req, a_save_side, a_overrun;
  logic       b_side, b_tr00_n, b_wps_n, b_save_req, b_save_side, b_overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  c15xx_head_ctrl #(.CHANGE_CYCLES(10), .SIDES(1)) dut_a (
    .clk(clk), .reset(reset), .mtr(mtr), .stp(stp), .act(act), .side_i(side_i),
    .buff_we(buff_we), .disk_change(disk_change), .disk_readonly(disk_readonly),
    .save_ack(save_ack), .track(a_track), .side(a_side), .tr00_sense_n(a_tr00_n),
    .wps_n(a_wps_n), .save_req(a_save_req), .save_track(a_save_track),
    .save_side(a_save_side), .overrun(a_overrun)
  );

  c15xx_head_ctrl #(.CHANGE_CYCLES(10), .SIDES(2)) dut_b (
    .clk(clk), .reset(reset), .mtr(mtr), .stp(stp), .act(act), .side_i(side_i),
    .buff_we(buff_we), .disk_change(disk_change), .disk_readonly(disk_readonly),
    .save_ack(save_ack), .track(b_track), .side(b_side), .tr00_sense_n(b_tr00_n),
    .wps_n(b_wps_n), .save_req(b_save_req), .save_track(b_save_track),
    .save_side(b_save_side), .overrun(b_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] next_up(input logic [1:0] s);
    case (s)
      2'd0:    return 2'd2;
      2'd2:    return 2'd1;
      2'd1:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] next_down(input logic [1:0] s);
    case (s)
      2'd0:    return 2'd3;
      2'd3:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  task automatic up_steps(input int n);
    for (int i = 0; i < n; i++) begin
      stp = next_up(stp);
      tick();
    end
  endtask

  task automatic down_steps(input int n);
    for (int i = 0; i < n; i++) begin
      stp = next_down(stp);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; mtr = 1'b0; stp = 2'd0; act = 1'b0; side_i = 1'b0;
    buff_we = 1'b0; disk_change = 1'b0; disk_readonly = 1'b0; save_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_track", a_track, 18);
    check("rst_tr00", a_tr00_n, 1);
    check("rst_wps", a_wps_n, 1);
    check("rst_req", a_save_req, 0);
    check("rst_strack", a_save_track, 0);
    check("rst_sside", a_save_side, 0);
    check("rst_ovr", a_overrun, 0);
    check("rst_side", a_side, 0);

    // Motor off: phases move but the head stays
    up_steps(3);
    check("mtr_off_track", a_track, 18);
    up_steps(1);

    mtr = 1'b1;
    up_steps(1);
    check("up1_track", a_track, 18);
    up_steps(2);
    check("up3_track", a_track, 19);

    down_steps(37);
    check("ht2_track", a_track, 1);
    check("ht2_tr00", a_tr00_n, 1);
    down_steps(4);
    check("ht1_track", a_track, 0);
    check("ht1_tr00", a_tr00_n, 0);
    check("clean_no_req", a_save_req, 0);

    // Clamped step with dirty buffer still raises a request; ack at first cycle
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    down_steps(1);
    check("clamp_req", a_save_req, 1);
    check("clamp_strack", a_save_track, 0);
    check("clamp_track", a_track, 0);
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    check("ack1_req", a_save_req, 0);

    up_steps(85);
    check("max_track", a_track, 40);
    down_steps(44);
    check("back_track", a_track, 18);

    // Dirty on track 18, step up, ack three cycles later
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    up_steps(1);
    check("save_req", a_save_req, 1);
    check("save_track", a_save_track, 18);
    tick(); tick();
    check("req_held", a_save_req, 1);
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    check("ack_req", a_save_req, 0);
    act = 1'b1; tick(); act = 1'b0; tick();
    check("dirty_cleared", a_save_req, 0);

    // Second dirty event while pending sets overrun
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    up_steps(1);
    check("req2", a_save_req, 1);
    check("req2_strack", a_save_track, 18);
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    act = 1'b1; tick(); act = 1'b0; tick();
    check("ovr_set", a_overrun, 1);
    check("ovr_strack", a_save_track, 18);
    check("ovr_req", a_save_req, 1);

    // Disk change: readonly image, window of 10 cycles, pending request dropped
    disk_readonly = 1'b1; disk_change = 1'b1; tick();
    check("dc_req_drop", a_save_req, 0);
    check("dc_wps0", a_wps_n, 1);
    for (int i = 0; i < 9; i++) tick();
    check("dc_wps9", a_wps_n, 1);
    tick();
    check("dc_wps10", a_wps_n, 0);
    check("ovr_sticky", a_overrun, 1);

    // Change edge in the same cycle as a dirty step issues nothing
    disk_change = 1'b0; disk_readonly = 1'b0; tick();
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    disk_change = 1'b1;
    up_steps(1);
    check("prio_req", a_save_req, 0);
    check("prio_wps", a_wps_n, 0);
    act = 1'b1; tick(); act = 1'b0; tick();
    check("prio_dirty_clr", a_save_req, 0);

    // Side change: only the double-sided instance reacts
    buff_we = 1'b1; side_i = 1'b1; tick(); buff_we = 1'b0;
    check("b_side_req", b_save_req, 1);
    check("b_save_side", b_save_side, 0);
    check("b_side", b_side, 1);
    check("a_side_noreq", a_save_req, 0);
    check("a_side", a_side, 0);

    // Reset mid-request drops it at once
    reset = 1'b1; tick();
    check("rst_mid_req", b_save_req, 0);
    check("rst_mid_track", b_track, 18);
    check("rst_mid_side", b_side, 0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
